// File: rtl/gin_scatter_if.sv
// Bus bundle for the GIN scatter controller: buffer-side push ports, PE-array
// broadcast/strobe/ready, ID scan chain and drop counter.
interface gin_scatter_if #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ROW_TAG_WIDTH = 4,
  parameter int unsigned COL_TAG_WIDTH = 4,
  parameter int unsigned NUM_OF_ROWS   = 12,
  parameter int unsigned NUM_OF_COLS   = 14
);

  logic [DATA_WIDTH-1:0]                      data_in;
  logic                                       data_wr_en;
  logic                                       data_full;
  logic [ROW_TAG_WIDTH-1:0]                   row_tag;
  logic [COL_TAG_WIDTH-1:0]                   col_tag;
  logic                                       tags_wr_en;
  logic                                       tags_full;
  logic [DATA_WIDTH-1:0]                      data_out;
  logic [0:NUM_OF_COLS-1][0:NUM_OF_ROWS-1]    enable_out;
  logic [0:NUM_OF_COLS-1][0:NUM_OF_ROWS-1]    ready_in;
  logic                                       scan_en_id;
  logic                                       scan_in_id;
  logic                                       scan_out_id;
  logic [15:0]                                dropped_count;

  modport slave (
    input  data_in, data_wr_en, row_tag, col_tag, tags_wr_en, ready_in,
           scan_en_id, scan_in_id,
    output data_full, tags_full, data_out, enable_out, scan_out_id,
           dropped_count
  );

  modport master (
    output data_in, data_wr_en, row_tag, col_tag, tags_wr_en, ready_in,
           scan_en_id, scan_in_id,
    input  data_full, tags_full, data_out, enable_out, scan_out_id,
           dropped_count
  );

endinterface

// File: rtl/gin_scatter.sv
// Global input network scatter: buffers tagged words and multicasts each to
// every PE whose scanned-in row/col ID matches, once all targets are ready.
module gin_scatter #(
  parameter int unsigned DATA_WIDTH          = 64,
  parameter int unsigned ROW_TAG_WIDTH       = 4,
  parameter int unsigned COL_TAG_WIDTH       = 4,
  parameter int unsigned NUM_OF_ROWS         = 12,
  parameter int unsigned NUM_OF_COLS         = 14,
  parameter int unsigned GIN_DATA_FIFO_DEPTH = 16,
  parameter int unsigned GIN_TAGS_FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  gin_scatter_if.slave    bus
);

  localparam int unsigned RW  = ROW_TAG_WIDTH;
  localparam int unsigned CW  = COL_TAG_WIDTH;
  localparam int unsigned R   = NUM_OF_ROWS;
  localparam int unsigned C   = NUM_OF_COLS;
  localparam int unsigned TW  = RW + CW;
  localparam int unsigned L   = R*RW + R*C*CW;
  localparam int unsigned DAW = $clog2(GIN_DATA_FIFO_DEPTH);
  localparam int unsigned TAW = $clog2(GIN_TAGS_FIFO_DEPTH);
  localparam logic [DAW:0] D_DEPTH = (DAW+1)'(GIN_DATA_FIFO_DEPTH);
  localparam logic [TAW:0] T_DEPTH = (TAW+1)'(GIN_TAGS_FIFO_DEPTH);

  typedef logic [0:C-1][0:R-1] mask_t;
  typedef enum logic [1:0] {S_IDLE, S_MATCH, S_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  dmem [GIN_DATA_FIFO_DEPTH];
  logic [TW-1:0]          tmem [GIN_TAGS_FIFO_DEPTH];
  logic [DAW-1:0]         dwr_q, dwr_d, drd_q, drd_d;
  logic [DAW:0]           dcnt_q, dcnt_d;
  logic                   dfull_q, dfull_d;
  logic [TAW-1:0]         twr_q, twr_d, trd_q, trd_d;
  logic [TAW:0]           tcnt_q, tcnt_d;
  logic                   tfull_q, tfull_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic [RW-1:0]          row_h_q, row_h_d;
  logic [CW-1:0]          col_h_q, col_h_d;
  mask_t                  mask_q, mask_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  mask_t                  enable_q, enable_d;
  logic [15:0]            dropped_q, dropped_d;
  logic [L-1:0]           chain_q, chain_d;

  logic                   d_push, t_push, pop;
  mask_t                  match_c;
  logic                   all_ready_c;

  assign d_push = bus.data_wr_en && !dfull_q;
  assign t_push = bus.tags_wr_en && !tfull_q;

  // Per-PE tag compare against the scanned-in IDs
  for (genvar r = 0; r < R; r++) begin : g_row
    for (genvar c = 0; c < C; c++) begin : g_col
      assign match_c[c][r] = (chain_q[r*RW +: RW] == row_h_q) &&
                             (chain_q[R*RW + (r*C+c)*CW +: CW] == col_h_q);
    end
  end

  // Non-target PEs are forced ready so only targets gate the send
  assign all_ready_c = &(~mask_q | bus.ready_in);

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    hold_d     = hold_q;
    row_h_d    = row_h_q;
    col_h_d    = col_h_q;
    mask_d     = mask_q;
    data_out_d = data_out_q;
    enable_d   = '0;
    dropped_d  = dropped_q;
    chain_d    = bus.scan_en_id ? {chain_q[L-2:0], bus.scan_in_id} : chain_q;

    unique case (state_q)
      S_IDLE: begin
        if ((dcnt_q != '0) && (tcnt_q != '0) && !bus.scan_en_id) begin
          pop                = 1'b1;
          hold_d             = dmem[drd_q];
          {col_h_d, row_h_d} = tmem[trd_q];
          state_d            = S_MATCH;
        end
      end
      S_MATCH: begin
        mask_d = match_c;
        if (match_c == '0) begin
          if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (all_ready_c) begin
          data_out_d = hold_q;
          enable_d   = mask_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    dwr_d   = dwr_q + DAW'(d_push);
    drd_d   = drd_q + DAW'(pop);
    dcnt_d  = dcnt_q + (DAW+1)'(d_push) - (DAW+1)'(pop);
    dfull_d = (dcnt_d == D_DEPTH);
    twr_d   = twr_q + TAW'(t_push);
    trd_d   = trd_q + TAW'(pop);
    tcnt_d  = tcnt_q + (TAW+1)'(t_push) - (TAW+1)'(pop);
    tfull_d = (tcnt_d == T_DEPTH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      dwr_q      <= '0;
      drd_q      <= '0;
      dcnt_q     <= '0;
      dfull_q    <= 1'b0;
      twr_q      <= '0;
      trd_q      <= '0;
      tcnt_q     <= '0;
      tfull_q    <= 1'b0;
      hold_q     <= '0;
      row_h_q    <= '0;
      col_h_q    <= '0;
      mask_q     <= '0;
      data_out_q <= '0;
      enable_q   <= '0;
      dropped_q  <= '0;
      chain_q    <= '0;
    end else begin
      state_q    <= state_d;
      dwr_q      <= dwr_d;
      drd_q      <= drd_d;
      dcnt_q     <= dcnt_d;
      dfull_q    <= dfull_d;
      twr_q      <= twr_d;
      trd_q      <= trd_d;
      tcnt_q     <= tcnt_d;
      tfull_q    <= tfull_d;
      hold_q     <= hold_d;
      row_h_q    <= row_h_d;
      col_h_q    <= col_h_d;
      mask_q     <= mask_d;
      data_out_q <= data_out_d;
      enable_q   <= enable_d;
      dropped_q  <= dropped_d;
      chain_q    <= chain_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by the counters
  always_ff @(posedge clk) begin
    if (d_push) dmem[dwr_q] <= bus.data_in;
    if (t_push) tmem[twr_q] <= {bus.col_tag, bus.row_tag};
  end

  assign bus.data_full     = dfull_q;
  assign bus.tags_full     = tfull_q;
  assign bus.data_out      = data_out_q;
  assign bus.enable_out    = enable_q;
  assign bus.scan_out_id   = chain_q[L-1];
  assign bus.dropped_count = dropped_q;

endmodule

// File: tb/tb_gin_scatter.sv
// Directed bench for gin_scatter: unicast, multicast, backpressure, drops,
// FIFO full/empty and asynchronous reset mid-transaction.
module tb_gin_scatter;

  localparam int unsigned DW = 64;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned R  = 12;
  localparam int unsigned C  = 14;
  localparam int unsigned L  = R*RW + R*C*CW;

  typedef logic [0:C-1][0:R-1] mask_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  gin_scatter_if #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW),
                   .NUM_OF_ROWS(R), .NUM_OF_COLS(C)) bus ();

  gin_scatter #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW),
                .NUM_OF_ROWS(R), .NUM_OF_COLS(C),
                .GIN_DATA_FIFO_DEPTH(16), .GIN_TAGS_FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // row_id[r]=r; col_id[r][c]=c, or 0 everywhere when col_zero is set
  function automatic logic [L-1:0] id_vec(input bit col_zero);
    logic [L-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++) begin
      v[r*RW +: RW] = RW'(r);
      for (int c = 0; c < C; c++)
        v[R*RW + (r*C+c)*CW +: CW] = col_zero ? CW'(0) : CW'(c);
    end
    return v;
  endfunction

  task automatic idle_inputs();
    bus.data_in    = '0;
    bus.data_wr_en = 1'b0;
    bus.row_tag    = '0;
    bus.col_tag    = '0;
    bus.tags_wr_en = 1'b0;
    bus.ready_in   = '1;
    bus.scan_en_id = 1'b0;
    bus.scan_in_id = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic scan_ids(input logic [L-1:0] v);
    for (int i = L-1; i >= 0; i--) begin
      bus.scan_en_id = 1'b1;
      bus.scan_in_id = v[i];
      @(negedge clk);
    end
    bus.scan_en_id = 1'b0;
    bus.scan_in_id = 1'b0;
  endtask

  task automatic push(input logic [RW-1:0] row, input logic [CW-1:0] col,
                      input logic [DW-1:0] data);
    bus.row_tag    = row;
    bus.col_tag    = col;
    bus.data_in    = data;
    bus.tags_wr_en = 1'b1;
    bus.data_wr_en = 1'b1;
    @(negedge clk);
    bus.tags_wr_en = 1'b0;
    bus.data_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.enable_out !== mask_t'(0)) begin errors++; $display("FAIL reset_enable: got %h expected 0", bus.enable_out); end
    checks++; if (bus.data_out !== 64'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", bus.data_out); end
    checks++; if (bus.dropped_count !== 16'h0) begin errors++; $display("FAIL reset_dropped: got %h expected 0", bus.dropped_count); end
    checks++; if (bus.data_full !== 1'b0 || bus.tags_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b%b expected 00", bus.data_full, bus.tags_full); end
    checks++; if (bus.scan_out_id !== 1'b0) begin errors++; $display("FAIL reset_scan_out: got %b expected 0", bus.scan_out_id); end
  endtask

  task automatic test_unicast();
    logic [L-1:0] v;
    mask_t exp;
    apply_reset();
    v = id_vec(1'b0);
    scan_ids(v);
    checks++; if (bus.scan_out_id !== v[L-1]) begin errors++; $display("FAIL scan_out: got %b expected %b", bus.scan_out_id, v[L-1]); end
    exp = '0;
    exp[5][2] = 1'b1;
    push(4'd2, 4'd5, 64'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.enable_out !== mask_t'(0)) begin errors++; $display("FAIL uni_early: got %h expected 0", bus.enable_out); end
    @(negedge clk);
    checks++; if (bus.enable_out !== exp) begin errors++; $display("FAIL uni_enable: got %h expected %h", bus.enable_out, exp); end
    checks++; if (bus.data_out !== 64'hDEAD_BEEF) begin errors++; $display("FAIL uni_data: got %h expected %h", bus.data_out, 64'hDEAD_BEEF); end
    @(negedge clk);
    checks++; if (bus.enable_out !== mask_t'(0)) begin errors++; $display("FAIL uni_pulse: got %h expected 0", bus.enable_out); end
    checks++; if (bus.data_out !== 64'hDEAD_BEEF) begin errors++; $display("FAIL uni_hold: got %h expected %h", bus.data_out, 64'hDEAD_BEEF); end
  endtask

  task automatic test_multicast();
    mask_t exp;
    apply_reset();
    scan_ids(id_vec(1'b1));
    exp = '0;
    for (int c = 0; c < C; c++) exp[c][3] = 1'b1;
    push(4'd3, 4'd0, 64'h1234_5678_9ABC_DEF0);
    repeat (3) @(negedge clk);
    checks++; if (bus.enable_out !== exp) begin errors++; $display("FAIL multi_enable: got %h expected %h", bus.enable_out, exp); end
    checks++; if (bus.data_out !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL multi_data: got %h expected %h", bus.data_out, 64'h1234_5678_9ABC_DEF0); end
  endtask

  task automatic test_backpressure();
    mask_t exp;
    int    early;
    apply_reset();
    scan_ids(id_vec(1'b0));
    exp = '0;
    exp[5][2] = 1'b1;
    bus.ready_in = '1;
    bus.ready_in[5][2] = 1'b0;
    push(4'd2, 4'd5, 64'hCAFE_0001);
    early = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.enable_out !== mask_t'(0)) early++;
      bus.ready_in = ~bus.ready_in;
      bus.ready_in[5][2] = 1'b0;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL bp_stall: got %0d strobes expected 0", early); end
    bus.ready_in[5][2] = 1'b1;
    @(negedge clk);
    checks++; if (bus.enable_out !== exp) begin errors++; $display("FAIL bp_enable: got %h expected %h", bus.enable_out, exp); end
    checks++; if (bus.data_out !== 64'hCAFE_0001) begin errors++; $display("FAIL bp_data: got %h expected %h", bus.data_out, 64'hCAFE_0001); end
    bus.ready_in = '1;
  endtask

  task automatic test_no_match();
    mask_t exp;
    int    early;
    apply_reset();
    scan_ids(id_vec(1'b0));
    push(4'd15, 4'd5, 64'hBAD0_BAD0);
    early = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.enable_out !== mask_t'(0)) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL nm_strobe: got %0d strobes expected 0", early); end
    checks++; if (bus.dropped_count !== 16'd1) begin errors++; $display("FAIL nm_dropped: got %0d expected 1", bus.dropped_count); end
    exp = '0;
    exp[3][7] = 1'b1;
    push(4'd7, 4'd3, 64'h0000_0707_0303);
    repeat (3) @(negedge clk);
    checks++; if (bus.enable_out !== exp) begin errors++; $display("FAIL nm_next_enable: got %h expected %h", bus.enable_out, exp); end
    checks++; if (bus.data_out !== 64'h0000_0707_0303) begin errors++; $display("FAIL nm_next_data: got %h expected %h", bus.data_out, 64'h0000_0707_0303); end
    checks++; if (bus.dropped_count !== 16'd1) begin errors++; $display("FAIL nm_dropped_hold: got %0d expected 1", bus.dropped_count); end
  endtask

  task automatic test_full_empty();
    mask_t exp;
    int    n;
    int    bad;
    apply_reset();
    scan_ids(id_vec(1'b0));
    exp = '0;
    exp[5][2] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.data_in    = 64'(100 + i);
      bus.data_wr_en = 1'b1;
      @(negedge clk);
      if (i == 15) begin
        checks++; if (bus.data_full !== 1'b1) begin errors++; $display("FAIL fe_full16: got %b expected 1", bus.data_full); end
      end
    end
    bus.data_wr_en = 1'b0;
    checks++; if (bus.data_full !== 1'b1) begin errors++; $display("FAIL fe_full17: got %b expected 1", bus.data_full); end
    checks++; if (bus.tags_full !== 1'b0) begin errors++; $display("FAIL fe_tags_full: got %b expected 0", bus.tags_full); end
    bus.row_tag = 4'd2;
    bus.col_tag = 4'd5;
    n   = 0;
    bad = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      bus.tags_wr_en = (cyc < 16);
      @(negedge clk);
      if (bus.enable_out !== mask_t'(0)) begin
        if (bus.enable_out !== exp || bus.data_out !== 64'(100 + n)) begin
          bad++;
          $display("FAIL fe_delivery: word %0d got %h/%h expected %h/%h", n, bus.data_out, bus.enable_out, 64'(100 + n), exp);
        end
        n++;
      end
    end
    checks++; if (bad != 0) errors++;
    checks++; if (n != 16) begin errors++; $display("FAIL fe_count: got %0d expected 16", n); end
    checks++; if (bus.data_full !== 1'b0 || bus.tags_full !== 1'b0) begin errors++; $display("FAIL fe_drained: got %b%b expected 00", bus.data_full, bus.tags_full); end
    bus.tags_wr_en = 1'b1;
    @(negedge clk);
    bus.tags_wr_en = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.enable_out !== mask_t'(0)) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL fe_empty: got %0d strobes expected 0", n); end
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    scan_ids(id_vec(1'b0));
    push(4'd2, 4'd5, 64'hA1A1_A1A1);
    repeat (4) @(negedge clk);
    checks++; if (bus.data_out !== 64'hA1A1_A1A1) begin errors++; $display("FAIL ar_pre_data: got %h expected %h", bus.data_out, 64'hA1A1_A1A1); end
    bus.ready_in[5][2] = 1'b0;
    push(4'd15, 4'd0, 64'h0F0F);
    push(4'd2, 4'd5, 64'hB2B2_B2B2);
    push(4'd1, 4'd1, 64'hC3C3_C3C3);
    repeat (8) @(negedge clk);
    checks++; if (bus.dropped_count !== 16'd1) begin errors++; $display("FAIL ar_pre_dropped: got %0d expected 1", bus.dropped_count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.enable_out !== mask_t'(0)) begin errors++; $display("FAIL ar_enable: got %h expected 0", bus.enable_out); end
    checks++; if (bus.data_out !== 64'h0) begin errors++; $display("FAIL ar_data: got %h expected 0", bus.data_out); end
    checks++; if (bus.dropped_count !== 16'h0) begin errors++; $display("FAIL ar_dropped: got %0d expected 0", bus.dropped_count); end
    checks++; if (bus.scan_out_id !== 1'b0) begin errors++; $display("FAIL ar_chain: got %b expected 0", bus.scan_out_id); end
    @(negedge clk);
    reset = 1'b1;
    bus.ready_in = '1;
    scan_ids(id_vec(1'b0));
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.enable_out !== mask_t'(0)) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL ar_fifo_flushed: got %0d strobes expected 0", n); end
  endtask

  initial begin
    clk    = 1'b0;
    reset  = 1'b0;
    checks = 0;
    errors = 0;
    idle_inputs();
    test_reset();
    test_unicast();
    test_multicast();
    test_backpressure();
    test_no_match();
    test_full_empty();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gin_scatter.md
Name: gin_scatter

Overview:
- Global input network scatter controller: the write-direction counterpart of the GON gather path.
- Accepts tagged data words from the global buffer into internal tag and data FIFOs.
- Multicasts each word to every PE whose scanned-in row/col ID matches the word's tag, once all targeted PEs report ready.
- Sits between the global buffer and the PE array data inputs.

Parameters:
DATA_WIDTH, 64, width of a data word
ROW_TAG_WIDTH, 4, row tag / row ID width
COL_TAG_WIDTH, 4, col tag / col ID width
NUM_OF_ROWS, 12, PE array rows
NUM_OF_COLS, 14, PE array columns
GIN_DATA_FIFO_DEPTH, 16, data FIFO entries (power of two)
GIN_TAGS_FIFO_DEPTH, 16, tag FIFO entries (power of two)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
data_in  in  DATA_WIDTH  word from global buffer
data_wr_en  in  1  push data_in
data_full  out  1  data FIFO full
row_tag  in  ROW_TAG_WIDTH  destination row tag
col_tag  in  COL_TAG_WIDTH  destination col tag
tags_wr_en  in  1  push {col_tag,row_tag}
tags_full  out  1  tag FIFO full
data_out  out  DATA_WIDTH  broadcast word to all PEs (registered)
enable_out  out  [0:NUM_OF_COLS-1] x [0:NUM_OF_ROWS-1]  per-PE write strobe (registered)
ready_in  in  [0:NUM_OF_COLS-1] x [0:NUM_OF_ROWS-1]  per-PE can-accept
scan_en_id, scan_in_id  in  1 each  ID scan chain shift enable / serial in
scan_out_id  out  1  ID scan chain serial out
dropped_count  out  16  saturating count of words matching no PE

Behaviour:
- Reset (reset low, async): FIFOs empty, FSM IDLE, data_out=0, enable_out all 0, ID chain all 0, dropped_count=0.
- FIFOs: synchronous, count-based. Full when count==DEPTH; empty flag deasserts the cycle after a write. A push while full is ignored, with no corruption. Pops occur only from the FSM.
- ID chain:
  - Length L = R*RW + R*C*CW.
  - When scan_en_id=1, each edge: chain <= {chain[L-2:0], scan_in_id}.
  - scan_out_id = chain[L-1].
  - row_id[r] = chain[r*RW +: RW].
  - col_id[r][c] = chain[R*RW + (r*C+c)*CW +: CW].
- FSM states IDLE, MATCH, WAIT:
  - IDLE: when both FIFOs are non-empty and scan_en_id=0, pop both together, latch word and tags into hold registers, go to MATCH.
  - MATCH: register target mask[r][c] = (row_id[r]==row_tag_h) && (col_id[r][c]==col_tag_h).
    - Mask all zero: dropped_count += 1 (saturate at 0xFFFF), go to IDLE.
    - Otherwise: go to WAIT.
  - WAIT: when every PE with mask=1 has ready_in=1 in the same cycle, next edge: data_out <= hold word, enable_out <= mask, go to IDLE. Otherwise hold, with enable_out 0. No timeout.
- enable_out is a one-cycle pulse. It clears on the following edge unless a new WAIT completion occurs. data_out holds its value until the next send.
- Latency: tag+data written at edge N → popped at edge N+1 → mask at N+2 → enable_out high after edge N+3 (all targets ready). Throughput: one word per 3 cycles.
- Tags and data are independent FIFOs. A transaction starts only when both are non-empty. An unpaired entry waits indefinitely.
- scan_en_id=1 blocks new pops only. An in-flight MATCH/WAIT completes using the IDs registered in MATCH. Changing IDs during WAIT does not alter the mask.
- ready_in of non-target PEs is ignored.
- Reset asserted mid-transaction: the held word is lost, outputs clear immediately, FIFO contents are discarded.

Test Plan:
- Scan ID pattern: row_id[r]=r, col_id[r][c]=c (L shifts). Push tag (row 2, col 5) with data 0xDEAD_BEEF, all ready=1 → enable_out[5][2] alone pulses 1 cycle after edge N+3, data_out=0xDEAD_BEEF.
- Multicast: all col_id=0, row_id[r]=r. Push row 3, col 0 → all 14 PEs of row 3 strobe in the same cycle.
- Backpressure: as the first test, but ready_in[5][2]=0 for 10 cycles → no strobe; strobe 1 cycle after ready rises. Toggling other PEs' ready has no effect.
- No match: push row 15 → no strobe, dropped_count=1. Next valid word is still delivered.
- Full/empty: push 17 words without tags → data_full high after 16, 17th ignored. Then push 16 tags → exactly 16 deliveries in order, FIFOs empty.
- Async reset in WAIT → enable_out=0, data_out=0, FIFOs empty, dropped_count=0 without a clock edge.
